// File: rtl/sched_dispatch_pkg.sv
// Shared definitions for the spike-scheduler dispatcher: event-type codes,
// FSM state encoding and the widths derived from the default array geometry.
package sched_pkg;

  localparam int WORDS  = 256 / 4;
  localparam int WORD_W = $clog2(WORDS);
  localparam int TS_W   = $clog2(8);

  localparam logic [1:0] VT_SPIKE  = 2'b00;
  localparam logic [1:0] VT_TICK   = 2'b01;
  localparam logic [1:0] VT_SSTART = 2'b10;
  localparam logic [1:0] VT_RSVD   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_RD,
    ST_CAP,
    ST_OUT
  } state_t;

endpackage

// File: rtl/sched_dispatch_if.sv
// Weight-word handoff from the dispatcher to the post-neuron update stage.
interface sched_dispatch_if #(
  parameter int PRE_NEUR_ADDR_WIDTH  = 10,
  parameter int WORD_W               = 6,
  parameter int SYN_ARRAY_DATA_WIDTH = 32
);
  logic                            DISP_VALID;
  logic                            DISP_READY;
  logic [PRE_NEUR_ADDR_WIDTH-1:0]  DISP_PRE_ADDR;
  logic [WORD_W-1:0]               DISP_WORD;
  logic [SYN_ARRAY_DATA_WIDTH-1:0] DISP_WEIGHTS;

  modport master (output DISP_VALID, DISP_PRE_ADDR, DISP_WORD, DISP_WEIGHTS,
                  input  DISP_READY);
  modport slave  (input  DISP_VALID, DISP_PRE_ADDR, DISP_WORD, DISP_WEIGHTS,
                  output DISP_READY);
endinterface

// File: rtl/sched_ts_counter.sv
// Modulo-TIME_STEP timestep counter; o_wrap pulses on the increment that
// rolls the last timestep back to zero.
module sched_ts_counter
  import sched_pkg::*;
#(
  parameter int TIME_STEP = 8
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            i_inc,
  input  logic            i_clr,
  output logic [TS_W-1:0] o_ts_idx,
  output logic            o_wrap
);

  logic [TS_W-1:0] r_idx;
  logic            w_at_last;

  assign w_at_last = (r_idx == TS_W'(TIME_STEP - 1));
  assign o_wrap    = i_inc && w_at_last;
  assign o_ts_idx  = r_idx;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)      r_idx <= '0;
    else if (i_clr) r_idx <= '0;
    else if (i_inc) r_idx <= w_at_last ? '0 : r_idx + TS_W'(1);
  end

endmodule

// File: rtl/sched_dispatch.sv
// Scheduler FIFO consumer: pops AER events, sweeps a spike's synapse row out
// over valid/ready, and tracks timesteps. Option: DISPATCH_SKIP_ZERO_EN.
module sched_dispatch
  import sched_pkg::*;
#(
  parameter int TIME_STEP            = 8,
  parameter int OUTPUT_NEURON        = 256,
  parameter int POST_NEUR_PARALLEL   = 4,
  parameter int PRE_NEUR_ADDR_WIDTH  = 10,
  parameter int AER_WIDTH            = 12,
  parameter int SYN_ARRAY_DATA_WIDTH = 32,
  parameter int SYN_ARRAY_ADDR_WIDTH = 16,
  parameter int WEIGHT_WIDTH         = 8
) (
  input  logic                            CLK,
  input  logic                            RSTN,
  input  logic                            ENABLE,
  input  logic                            SCHED_EMPTY,
  input  logic [AER_WIDTH-1:0]            SCHED_DATA_OUT,
  output logic                            CTRL_SCHED_POP_N,
  output logic                            SYN_RD_EN,
  output logic [SYN_ARRAY_ADDR_WIDTH-1:0] SYN_ADDR,
  input  logic [SYN_ARRAY_DATA_WIDTH-1:0] SYN_RDATA,
  sched_dispatch_if.master                disp,
  output logic                            TS_TICK,
  output logic [TS_W-1:0]                 TS_IDX,
  output logic                            SAMPLE_DONE,
  output logic                            DISP_BUSY
);

  localparam int                ROW_W     = POST_NEUR_PARALLEL * WEIGHT_WIDTH;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(OUTPUT_NEURON / POST_NEUR_PARALLEL - 1);

  state_t                         r_state, w_next;
  logic [AER_WIDTH-1:0]           r_evt;
  logic [WORD_W-1:0]              r_word;
  logic [PRE_NEUR_ADDR_WIDTH-1:0] r_out_pre;
  logic [WORD_W-1:0]              r_out_word;
  logic [ROW_W-1:0]               r_out_weights;

  logic [1:0]                     w_virts;
  logic [PRE_NEUR_ADDR_WIDTH-1:0] w_pre;
  logic                           w_last;
  logic                           w_skip;
  logic                           w_ts_inc;
  logic                           w_ts_clr;

  assign w_virts = r_evt[AER_WIDTH-1 -: 2];
  assign w_pre   = r_evt[PRE_NEUR_ADDR_WIDTH-1:0];
  assign w_last  = (r_word == LAST_WORD);

`ifdef DISPATCH_SKIP_ZERO_EN
  assign w_skip = (SYN_RDATA[ROW_W-1:0] == '0);
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (ENABLE && !SCHED_EMPTY) w_next = ST_FETCH;
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: w_next = (w_virts == VT_SPIKE) ? ST_RD : ST_IDLE;
      ST_RD:     w_next = ST_CAP;
      ST_CAP:    if (w_skip) w_next = w_last ? ST_IDLE : ST_RD;
                 else        w_next = ST_OUT;
      ST_OUT:    if (disp.DISP_READY) w_next = w_last ? ST_IDLE : ST_RD;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Event register, row cursor and the held output word
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_evt         <= '0;
      r_word        <= '0;
      r_out_pre     <= '0;
      r_out_word    <= '0;
      r_out_weights <= '0;
    end else begin
      case (r_state)
        ST_FETCH:  r_evt  <= SCHED_DATA_OUT;
        ST_DECODE: r_word <= '0;
        ST_CAP: begin
          r_out_pre     <= w_pre;
          r_out_word    <= r_word;
          r_out_weights <= SYN_RDATA[ROW_W-1:0];
          if (w_skip && !w_last) r_word <= r_word + WORD_W'(1);
        end
        ST_OUT:    if (disp.DISP_READY && !w_last) r_word <= r_word + WORD_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    SYN_ADDR = '0;
    if (r_state == ST_RD) SYN_ADDR = {w_pre, r_word};
  end

  assign CTRL_SCHED_POP_N  = (r_state != ST_FETCH);
  assign SYN_RD_EN         = (r_state == ST_RD);
  assign DISP_BUSY         = (r_state != ST_IDLE);
  assign disp.DISP_VALID    = (r_state == ST_OUT);
  assign disp.DISP_PRE_ADDR = r_out_pre;
  assign disp.DISP_WORD     = r_out_word;
  assign disp.DISP_WEIGHTS  = r_out_weights;

  assign w_ts_inc = (r_state == ST_DECODE) && (w_virts == VT_TICK);
  assign w_ts_clr = (r_state == ST_DECODE) && (w_virts == VT_SSTART);
  assign TS_TICK  = w_ts_inc;

  sched_ts_counter #(.TIME_STEP(TIME_STEP)) u_ts (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .i_inc    (w_ts_inc),
    .i_clr    (w_ts_clr),
    .o_ts_idx (TS_IDX),
    .o_wrap   (SAMPLE_DONE)
  );

endmodule

// File: tb/tb_sched_dispatch.sv
// Bench for sched_dispatch: FIFO and synapse-memory models, randomized rows and
// READY patterns, expected beats derived from the row contents.
module tb_sched_dispatch;
  import sched_pkg::*;

`ifdef DISPATCH_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        CLK = 1'b0, RSTN = 1'b0, ENABLE = 1'b0;
  logic        SCHED_EMPTY;
  logic [11:0] SCHED_DATA_OUT;
  logic        POP_N, SYN_RD_EN, TS_TICK, SAMPLE_DONE, BUSY;
  logic [15:0] SYN_ADDR;
  logic [31:0] SYN_RDATA = '0;
  logic [2:0]  TS_IDX;

  sched_dispatch_if #(.PRE_NEUR_ADDR_WIDTH(10), .WORD_W(6), .SYN_ARRAY_DATA_WIDTH(32)) disp ();

  sched_dispatch dut (
    .CLK(CLK), .RSTN(RSTN), .ENABLE(ENABLE), .SCHED_EMPTY(SCHED_EMPTY),
    .SCHED_DATA_OUT(SCHED_DATA_OUT), .CTRL_SCHED_POP_N(POP_N),
    .SYN_RD_EN(SYN_RD_EN), .SYN_ADDR(SYN_ADDR), .SYN_RDATA(SYN_RDATA),
    .disp(disp), .TS_TICK(TS_TICK), .TS_IDX(TS_IDX),
    .SAMPLE_DONE(SAMPLE_DONE), .DISP_BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Show-ahead scheduler FIFO model
  logic [11:0] fifo [0:63];
  int wr_ptr = 0, rd_ptr = 0;
  assign SCHED_EMPTY    = (rd_ptr == wr_ptr);
  assign SCHED_DATA_OUT = fifo[rd_ptr % 64];
  always @(posedge CLK) if (RSTN && !POP_N && rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;

  // Synapse row model: one-cycle read latency
  logic [31:0] mem [0:63];
  always @(posedge CLK) SYN_RDATA <= mem[SYN_ADDR[5:0]];

  int n_pass = 0, n_checks = 0;

  int          n_pop, n_tick, stray_done, stab_err, k_pop, k_rd, k_valid, k_last, k_tick;
  bit          timed_out;
  int          obs_pre[$], obs_word[$];
  logic [31:0] obs_w[$];
  logic [15:0] rd_addr[$];
  int          tick_idx[$], tick_done[$];
  int          exp_word[$];
  logic [31:0] exp_w[$];

  task automatic push(input logic [1:0] vt, input int addr);
    fifo[wr_ptr % 64] = {vt, 10'(addr)};
    wr_ptr = wr_ptr + 1;
  endtask

  // Expected beats for one row: every word, or only nonzero words when skipping
  task automatic build_expected();
    exp_word.delete(); exp_w.delete();
    for (int w = 0; w < WORDS; w++)
      if (!(SKIP && mem[w] == 32'd0)) begin
        exp_word.push_back(w); exp_w.push_back(mem[w]);
      end
  endtask

  task automatic drive_sweep(input int max_cyc, input bit rand_ready, input int en_off_at);
    bit pv = 0, pr = 0, done = 0;
    logic [47:0] pd = '0, cd;
    n_pop = 0; n_tick = 0; stray_done = 0; stab_err = 0;
    k_pop = -1; k_rd = -1; k_valid = -1; k_last = -1; k_tick = -1; timed_out = 0;
    obs_pre.delete(); obs_word.delete(); obs_w.delete(); rd_addr.delete();
    tick_idx.delete(); tick_done.delete();
    for (int k = 1; k <= max_cyc && !done; k++) begin
      @(negedge CLK);
      if (rand_ready) disp.DISP_READY = ($urandom_range(0, 2) != 0);
      if (k == en_off_at) ENABLE = 1'b0;
      cd = {disp.DISP_PRE_ADDR, disp.DISP_WORD, disp.DISP_WEIGHTS};
      if (!POP_N) begin n_pop++; if (k_pop < 0) k_pop = k; end
      if (SYN_RD_EN) begin rd_addr.push_back(SYN_ADDR); if (k_rd < 0) k_rd = k; end
      if (disp.DISP_VALID && k_valid < 0) k_valid = k;
      if (pv && !pr && (!disp.DISP_VALID || cd != pd)) stab_err++;
      if (disp.DISP_VALID && disp.DISP_READY) begin
        obs_pre.push_back(int'(disp.DISP_PRE_ADDR)); obs_word.push_back(int'(disp.DISP_WORD));
        obs_w.push_back(disp.DISP_WEIGHTS); k_last = k;
      end
      if (TS_TICK) begin
        n_tick++; tick_idx.push_back(int'(TS_IDX)); tick_done.push_back(int'(SAMPLE_DONE));
        if (k_tick < 0) k_tick = k;
      end else if (SAMPLE_DONE) stray_done++;
      pv = disp.DISP_VALID; pr = disp.DISP_READY; pd = cd;
      if (k > 1 && !BUSY && (SCHED_EMPTY || !ENABLE)) done = 1;
    end
    if (!done) timed_out = 1;
  endtask

  task automatic test_reset();
    logic [72:0] obs;
    ENABLE = 1'b0; disp.DISP_READY = 1'b0; RSTN = 1'b0;
    repeat (3) @(negedge CLK);
    obs = {POP_N, SYN_RD_EN, SYN_ADDR, disp.DISP_VALID, disp.DISP_PRE_ADDR, disp.DISP_WORD,
           disp.DISP_WEIGHTS, TS_TICK, TS_IDX, SAMPLE_DONE, BUSY};
    n_checks++;
    if (obs !== {1'b1, 72'd0}) $display("FAIL reset_outputs got %h want %h", obs, {1'b1, 72'd0});
    else n_pass++;
    RSTN = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (BUSY !== 1'b0 || POP_N !== 1'b1) $display("FAIL reset_idle busy=%b pop_n=%b want 0/1", BUSY, POP_N);
    else n_pass++;
  endtask

  task automatic test_spike_row();
    for (int w = 0; w < WORDS; w++) mem[w] = 32'(w + 1);
    build_expected();
    ENABLE = 1'b1; disp.DISP_READY = 1'b1;
    @(negedge CLK); push(VT_SPIKE, 5);
    drive_sweep(400, 0, -1);
    n_checks++;
    if (timed_out || n_pop !== 1) $display("FAIL spike_pop timeout=%0d pops=%0d want 0/1", timed_out, n_pop);
    else n_pass++;
    n_checks++;
    if (k_pop !== 1 || k_rd !== 3 || k_valid !== 5)
      $display("FAIL spike_latency pop=%0d rd=%0d valid=%0d want 1/3/5", k_pop, k_rd, k_valid);
    else n_pass++;
    n_checks++;
    if (k_last !== 5 + 3 * (WORDS - 1)) $display("FAIL spike_last_beat got %0d want %0d", k_last, 5 + 3 * (WORDS - 1));
    else n_pass++;
    n_checks++;
    if (obs_word.size() !== WORDS || rd_addr.size() !== WORDS)
      $display("FAIL spike_counts beats=%0d reads=%0d want %0d", obs_word.size(), rd_addr.size(), WORDS);
    else n_pass++;
    for (int i = 0; i < obs_word.size() && i < WORDS; i++) begin
      n_checks++;
      if (obs_word[i] !== i || obs_pre[i] !== 5 || obs_w[i] !== 32'(i + 1) || rd_addr[i] !== 16'(16'h0140 + i))
        $display("FAIL spike_beat[%0d] got pre=%0d word=%0d w=%h addr=%h want 5/%0d/%h/%h",
                 i, obs_pre[i], obs_word[i], obs_w[i], rd_addr[i], i, i + 1, 16'h0140 + i);
      else n_pass++;
    end
  endtask

  task automatic test_ticks();
    int ts = 0;
    push(VT_SSTART, 0);
    for (int i = 0; i < 8; i++) push(VT_TICK, $urandom_range(0, 1023));
    drive_sweep(300, 0, -1);
    n_checks++;
    if (timed_out || n_pop !== 9 || n_tick !== 8 || stray_done !== 0)
      $display("FAIL tick_counts timeout=%0d pops=%0d ticks=%0d stray=%0d want 0/9/8/0", timed_out, n_pop, n_tick, stray_done);
    else n_pass++;
    for (int i = 0; i < tick_idx.size(); i++) begin
      n_checks++;
      if (tick_idx[i] !== ts || tick_done[i] !== int'(ts == 7))
        $display("FAIL tick[%0d] got idx=%0d done=%0d want %0d/%0d", i, tick_idx[i], tick_done[i], ts, ts == 7);
      else n_pass++;
      ts = (ts + 1) % 8;
    end
    n_checks++;
    if (TS_IDX !== 3'(ts)) $display("FAIL tick_final got %0d want %0d", TS_IDX, ts);
    else n_pass++;
    @(negedge CLK); push(VT_TICK, 0);
    drive_sweep(50, 0, -1);
    n_checks++;
    if (k_tick !== 2 || TS_IDX !== 3'd1) $display("FAIL tick_timing k=%0d idx=%0d want 2/1", k_tick, TS_IDX);
    else n_pass++;
    push(VT_TICK, 0); push(VT_SSTART, 0);
    drive_sweep(50, 0, -1);
    n_checks++;
    if (TS_IDX !== 3'd0 || n_tick !== 1) $display("FAIL sample_start_clear idx=%0d ticks=%0d want 0/1", TS_IDX, n_tick);
    else n_pass++;
  endtask

  task automatic test_random_ready();
    int pre = $urandom_range(0, 1023);
    for (int w = 0; w < WORDS; w++) mem[w] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    build_expected();
    @(negedge CLK); push(VT_SPIKE, pre); push(VT_RSVD, 0);
    drive_sweep(3000, 1, 2);
    n_checks++;
    if (timed_out || n_pop !== 1 || wr_ptr - rd_ptr !== 1)
      $display("FAIL rr_enable_hold timeout=%0d pops=%0d left=%0d want 0/1/1", timed_out, n_pop, wr_ptr - rd_ptr);
    else n_pass++;
    n_checks++;
    if (stab_err !== 0) $display("FAIL rr_stability got %0d unstable cycles want 0", stab_err);
    else n_pass++;
    n_checks++;
    if (obs_word.size() !== exp_word.size()) $display("FAIL rr_count got %0d want %0d", obs_word.size(), exp_word.size());
    else n_pass++;
    for (int i = 0; i < obs_word.size() && i < exp_word.size(); i++) begin
      n_checks++;
      if (obs_word[i] !== exp_word[i] || obs_pre[i] !== pre || obs_w[i] !== exp_w[i])
        $display("FAIL rr_beat[%0d] got %0d/%0d/%h want %0d/%0d/%h", i, obs_pre[i], obs_word[i], obs_w[i], pre, exp_word[i], exp_w[i]);
      else n_pass++;
    end
    disp.DISP_READY = 1'b1; ENABLE = 1'b1;
    drive_sweep(50, 0, -1);
    n_checks++;
    if (n_pop !== 1 || obs_word.size() !== 0 || n_tick !== 0)
      $display("FAIL rr_drain pops=%0d beats=%0d ticks=%0d want 1/0/0", n_pop, obs_word.size(), n_tick);
    else n_pass++;
  endtask

  task automatic test_reserved_then_spike();
    for (int w = 0; w < WORDS; w++) mem[w] = $urandom | 32'h1;
    build_expected();
    @(negedge CLK); push(VT_RSVD, $urandom_range(0, 1023)); push(VT_SPIKE, 3);
    drive_sweep(400, 0, -1);
    n_checks++;
    if (timed_out || n_pop !== 2 || n_tick !== 0 || k_valid !== 8)
      $display("FAIL rsvd_flow timeout=%0d pops=%0d ticks=%0d first_valid=%0d want 0/2/0/8", timed_out, n_pop, n_tick, k_valid);
    else n_pass++;
    n_checks++;
    if (obs_word.size() !== WORDS || obs_pre[0] !== 3 || obs_word[WORDS-1] !== WORDS - 1 || obs_w[9] !== mem[9])
      $display("FAIL rsvd_spike beats=%0d pre=%0d last=%0d w9=%h want %0d/3/%0d/%h",
               obs_word.size(), obs_pre[0], obs_word[obs_word.size()-1], obs_w[9], WORDS, WORDS - 1, mem[9]);
    else n_pass++;
  endtask

  task automatic test_skip_zero();
    int pre = $urandom_range(0, 1023);
    for (int w = 0; w < WORDS; w++) mem[w] = 32'd0;
    mem[7] = $urandom | 32'h100;
    build_expected();
    @(negedge CLK); push(VT_SPIKE, pre);
    drive_sweep(400, 0, -1);
    n_checks++;
    if (timed_out || obs_word.size() !== exp_word.size() || rd_addr.size() !== WORDS)
      $display("FAIL skip_counts timeout=%0d beats=%0d reads=%0d want 0/%0d/%0d", timed_out, obs_word.size(), rd_addr.size(), exp_word.size(), WORDS);
    else n_pass++;
    for (int i = 0; i < obs_word.size() && i < exp_word.size(); i++) begin
      n_checks++;
      if (obs_word[i] !== exp_word[i] || obs_w[i] !== exp_w[i] || obs_pre[i] !== pre)
        $display("FAIL skip_beat[%0d] got %0d/%h want %0d/%h", i, obs_word[i], obs_w[i], exp_word[i], exp_w[i]);
      else n_pass++;
    end
  endtask

  task automatic test_rst_mid();
    logic [72:0] obs;
    bit hit = 0;
    for (int w = 0; w < WORDS; w++) mem[w] = 32'(w + 1);
    @(negedge CLK); push(VT_TICK, 0);
    drive_sweep(50, 0, -1);
    push(VT_SPIKE, 9);
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge CLK);
      if (disp.DISP_VALID && disp.DISP_WORD == 6'd20) hit = 1;
    end
    n_checks++;
    if (!hit) $display("FAIL rst_reach_word20 got no beat at word 20 within 200 cycles");
    else n_pass++;
    RSTN = 1'b0; #1;
    obs = {POP_N, SYN_RD_EN, SYN_ADDR, disp.DISP_VALID, disp.DISP_PRE_ADDR, disp.DISP_WORD,
           disp.DISP_WEIGHTS, TS_TICK, TS_IDX, SAMPLE_DONE, BUSY};
    n_checks++;
    if (obs !== {1'b1, 72'd0}) $display("FAIL rst_mid_outputs got %h want %h", obs, {1'b1, 72'd0});
    else n_pass++;
    @(negedge CLK); RSTN = 1'b1;
    n_checks++;
    if (!SCHED_EMPTY) $display("FAIL rst_event_lost got fifo nonempty want empty");
    else n_pass++;
    @(negedge CLK); push(VT_SPIKE, 9);
    drive_sweep(400, 0, -1);
    n_checks++;
    if (timed_out || rd_addr.size() !== WORDS || rd_addr[0] !== 16'h0240 || obs_word.size() !== WORDS || obs_word[0] !== 0)
      $display("FAIL rst_restart timeout=%0d reads=%0d addr0=%h beats=%0d word0=%0d want 0/%0d/0240/%0d/0",
               timed_out, rd_addr.size(), rd_addr[0], obs_word.size(), obs_word[0], WORDS, WORDS);
    else n_pass++;
  endtask

  initial begin
    disp.DISP_READY = 1'b0;
    for (int w = 0; w < WORDS; w++) mem[w] = '0;
    test_reset();
    test_spike_row();
    test_ticks();
    test_random_ready();
    test_reserved_then_spike();
    test_skip_zero();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
